// File: rtl/left_shift_sequencer.sv
// rtl/left_shift_sequencer.sv - multi-cycle left shifter, one bit position per clock
// Reports the shifted result, the last bit shifted out and the arithmetic sign-change overflow.
module left_shift_sequencer #(
    parameter int width = 16,
    parameter int amt_w = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] in,
    input  logic [amt_w-1:0] amount,
    input  logic             mode,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] out,
    output logic             carry,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [amt_w-1:0] width_amt = amt_w'(width);
    localparam logic [amt_w-1:0] one_amt   = amt_w'(1);

    state_t           state;
    state_t           state_next;
    logic [amt_w-1:0] count;
    logic [amt_w-1:0] amt_clamped;
    logic             mode_r;
    logic             accept;

    assign amt_clamped = (amount > width_amt) ? width_amt : amount;
    assign accept      = start && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (amt_clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                ready = 1'b0;
                busy  = 1'b1;
                if (count == one_amt) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // back-to-back: a start in the done cycle begins the next operation
                if (start) begin
                    state_next = (amt_clamped == '0) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out    <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            count  <= '0;
            mode_r <= 1'b0;
        end else if (accept) begin
            out    <= in;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            count  <= amt_clamped;
            mode_r <= mode;
        end else if (state == SHIFT) begin
            out   <= {out[width-2:0], 1'b0};
            carry <= out[width-1];
            // sign bit is about to change: sticky arithmetic overflow
            if (!mode_r && (out[width-1] != out[width-2])) begin
                ovf <= 1'b1;
            end
            count <= count - one_amt;
        end
    end

endmodule
